// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
// Issues one ACE snoop at a time on the AC channel, then collects the CR
// response and any CD data beats, and returns a single line-sized result.
// The snoop-side struct ports are flattened into plain AC/CR/CD signals.
// Optional feature: define ACE_SNOOP_INIT_TIMEOUT_EN to add a watchdog. The
// watchdog forces a result with an error after TIMEOUT_CYC cycles without a
// handshake. When the macro is not defined, the block waits indefinitely.
module ace_snoop_initiator #(
   parameter int CD_WIDTH    = 64,
   parameter int LINE_WIDTH  = 128,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // request side
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [63:0]           req_addr_i,
   input  logic [3:0]            req_snoop_i,
   // AC channel (towards the cache)
   output logic                  ac_valid_o,
   input  logic                  ac_ready_i,
   output logic [63:0]           ac_addr_o,
   output logic [3:0]            ac_snoop_o,
   output logic [2:0]            ac_prot_o,
   // CR channel
   input  logic                  cr_valid_i,
   output logic                  cr_ready_o,
   input  logic [4:0]            cr_resp_i,
   // CD channel
   input  logic                  cd_valid_i,
   output logic                  cd_ready_o,
   input  logic [CD_WIDTH-1:0]   cd_data_i,
   input  logic                  cd_last_i,
   // result side
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [4:0]            rsp_crresp_o,
   output logic [LINE_WIDTH-1:0] rsp_data_o,
   output logic                  rsp_err_o
);

   localparam int NR_BEATS = LINE_WIDTH / CD_WIDTH;
   localparam int BW       = $clog2(NR_BEATS) + 1;
   localparam int BYTE_OFF = $clog2(LINE_WIDTH / 8);

   localparam logic [BW-1:0] NR_BEATS_C = BW'(NR_BEATS);
   localparam logic [63:0]   ADDR_MASK  = ~((64'd1 << BYTE_OFF) - 64'd1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AC   = 3'd1;
   localparam logic [2:0] S_RESP = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // The line must split into a power-of-two number of whole CD beats.
   if (NR_BEATS < 1 || (NR_BEATS & (NR_BEATS - 1)) != 0 ||
       LINE_WIDTH != NR_BEATS * CD_WIDTH || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("ace_snoop_initiator: unsupported CD_WIDTH/LINE_WIDTH/TIMEOUT_CYC");
   end

   logic [2:0]            state_q,     state_d;
   logic [63:0]           addr_q,      addr_d;
   logic [3:0]            snoop_q,     snoop_d;
   logic                  ac_valid_q,  ac_valid_d;
   logic                  cr_ready_q,  cr_ready_d;
   logic                  cd_ready_q,  cd_ready_d;
   logic [BW-1:0]         beat_cnt_q,  beat_cnt_d;
   logic                  last_seen_q, last_seen_d;
   logic [LINE_WIDTH-1:0] data_q,      data_d;
   logic [4:0]            crresp_q,    crresp_d;
   logic                  err_q,       err_d;

   logic req_fire;
   logic ac_fire;
   logic cr_fire;
   logic cd_fire;

   assign req_fire = (state_q == S_IDLE) & req_valid_i;
   assign ac_fire  = ac_valid_q & ac_ready_i;
   assign cr_fire  = cr_ready_q & cr_valid_i;
   assign cd_fire  = cd_ready_q & cd_valid_i;

`ifdef ACE_SNOOP_INIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [TW-1:0] to_cnt_inc;
   logic          to_active;
   logic          to_hs;
   logic          to_fire;

   assign to_active  = (state_q == S_AC) | (state_q == S_RESP) | (state_q == S_DATA);
   assign to_hs      = req_fire | ac_fire | cr_fire | cd_fire;
   assign to_cnt_inc = to_cnt_q + TW'(1);
   assign to_fire    = to_active & ~to_hs & (to_cnt_inc == TW'(TIMEOUT_CYC));

   // Watchdog count: cycles waited since the most recent handshake.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (to_hs) begin
         to_cnt_d = TW'(1);
      end else if (to_active) begin
         to_cnt_d = to_cnt_inc;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`endif

   // Next-state logic: beat capture, the handshake FSM, and the optional watchdog override.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      snoop_d     = snoop_q;
      ac_valid_d  = ac_valid_q;
      cr_ready_d  = cr_ready_q;
      cd_ready_d  = cd_ready_q;
      beat_cnt_d  = beat_cnt_q;
      last_seen_d = last_seen_q;
      data_d      = data_q;
      crresp_d    = crresp_q;
      err_d       = err_q;

      // CD beats may arrive before, with or after CR; they are buffered the same way.
      if (cd_fire) begin
         if (beat_cnt_q < NR_BEATS_C) begin
            for (int b = 0; b < NR_BEATS; b++) begin
               if (beat_cnt_q == BW'(b)) begin
                  data_d[b*CD_WIDTH +: CD_WIDTH] = cd_data_i;
               end
            end
            beat_cnt_d = beat_cnt_q + BW'(1);
            // A last beat before the line is full leaves the missing beats at zero.
            if (cd_last_i && (beat_cnt_q != NR_BEATS_C - BW'(1))) begin
               err_d = 1'b1;
            end
         end else begin
            // An excess beat is consumed to keep the channel moving, but it is flagged.
            err_d = 1'b1;
         end
         if (cd_last_i) begin
            last_seen_d = 1'b1;
            cd_ready_d  = 1'b0;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               state_d     = S_AC;
               addr_d      = req_addr_i & ADDR_MASK;
               snoop_d     = req_snoop_i;
               ac_valid_d  = 1'b1;
               beat_cnt_d  = '0;
               last_seen_d = 1'b0;
               data_d      = '0;
               crresp_d    = '0;
               err_d       = 1'b0;
            end
         end
         S_AC: begin
            if (ac_fire) begin
               state_d    = S_RESP;
               ac_valid_d = 1'b0;
               cr_ready_d = 1'b1;
               cd_ready_d = 1'b1;
            end
         end
         S_RESP: begin
            if (cr_fire) begin
               crresp_d   = cr_resp_i;
               cr_ready_d = 1'b0;
               if (!cr_resp_i[0]) begin
                  // No data transfer: stop offering CD ready.
                  state_d    = S_DONE;
                  cd_ready_d = 1'b0;
               end else if (last_seen_q || (cd_fire && cd_last_i)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (cd_fire && cd_last_i) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef ACE_SNOOP_INIT_TIMEOUT_EN
      if (to_fire) begin
         state_d    = S_DONE;
         ac_valid_d = 1'b0;
         cr_ready_d = 1'b0;
         cd_ready_d = 1'b0;
         err_d      = 1'b1;
         crresp_d   = 5'b00010;
      end
`endif
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         snoop_q     <= '0;
         ac_valid_q  <= 1'b0;
         cr_ready_q  <= 1'b0;
         cd_ready_q  <= 1'b0;
         beat_cnt_q  <= '0;
         last_seen_q <= 1'b0;
         data_q      <= '0;
         crresp_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         snoop_q     <= snoop_d;
         ac_valid_q  <= ac_valid_d;
         cr_ready_q  <= cr_ready_d;
         cd_ready_q  <= cd_ready_d;
         beat_cnt_q  <= beat_cnt_d;
         last_seen_q <= last_seen_d;
         data_q      <= data_d;
         crresp_q    <= crresp_d;
         err_q       <= err_d;
      end
   end

   // All outputs come straight from registers.
   assign req_ready_o  = (state_q == S_IDLE);
   assign ac_valid_o   = ac_valid_q;
   assign ac_addr_o    = addr_q;
   assign ac_snoop_o   = snoop_q;
   assign ac_prot_o    = 3'b000;
   assign cr_ready_o   = cr_ready_q;
   assign cd_ready_o   = cd_ready_q;
   assign rsp_valid_o  = (state_q == S_DONE);
   assign rsp_crresp_o = crresp_q;
   assign rsp_data_o   = data_q;
   assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator: table of snoop transactions plus
// hand-written sequences for turnaround, result hold, async reset and the
// optional watchdog (ACE_SNOOP_INIT_TIMEOUT_EN).
module tb_ace_snoop_initiator;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid, req_ready_o;
   logic [63:0]  req_addr;
   logic [3:0]   req_snoop;
   logic         ac_valid_o, ac_ready;
   logic [63:0]  ac_addr_o;
   logic [3:0]   ac_snoop_o;
   logic [2:0]   ac_prot_o;
   logic         cr_valid, cr_ready_o;
   logic [4:0]   cr_resp;
   logic         cd_valid, cd_ready_o, cd_last;
   logic [63:0]  cd_data;
   logic         rsp_valid_o, rsp_ready;
   logic [4:0]   rsp_crresp_o;
   logic [127:0] rsp_data_o;
   logic         rsp_err_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ace_snoop_initiator #(
      .CD_WIDTH(64), .LINE_WIDTH(128), .TIMEOUT_CYC(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr), .req_snoop_i(req_snoop),
      .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready),
      .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
      .cr_valid_i(cr_valid), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp),
      .cd_valid_i(cd_valid), .cd_ready_o(cd_ready_o),
      .cd_data_i(cd_data), .cd_last_i(cd_last),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
      .rsp_crresp_o(rsp_crresp_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
   );

   // mode: 0 = CR then beats, 1 = all beats then CR, 2 = last beat together with CR
   typedef struct packed {
      logic [3:0]       snoop;
      logic [63:0]      addr;
      int               ac_wait;
      int               mode;
      logic [4:0]       cr;
      int               nbeats;
      int               last_idx;
      logic [2:0][63:0] beat;
      logic [63:0]      exp_addr;
      logic [127:0]     exp_data;
      logic [4:0]       exp_cr;
      logic             exp_err;
   } vec_t;

   vec_t tbl [7];

   function automatic vec_t mk(input logic [3:0] sn, input logic [63:0] a, input int acw,
                               input int md, input logic [4:0] cr, input int nb, input int li,
                               input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2,
                               input logic [63:0] ea, input logic [127:0] ed,
                               input logic [4:0] ec, input logic ee);
      vec_t v;
      v.snoop = sn; v.addr = a; v.ac_wait = acw; v.mode = md; v.cr = cr;
      v.nbeats = nb; v.last_idx = li;
      v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2;
      v.exp_addr = ea; v.exp_data = ed; v.exp_cr = ec; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ctl"}, {req_ready_o, ac_valid_o, cr_ready_o, cd_ready_o,
                          rsp_valid_o, rsp_crresp_o, rsp_err_o}, {1'b1, 4'b0000, 5'b00000, 1'b0});
      chk({tag, "_data"}, rsp_data_o, 128'h0);
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_addr = '0; req_snoop = '0; ac_ready = 0;
      cr_valid = 0; cr_resp = '0; cd_valid = 0; cd_data = '0; cd_last = 0; rsp_ready = 0;
   endtask

   task automatic send_cr(input logic [4:0] r);
      cr_valid = 1; cr_resp = r;
      @(negedge clk);
      cr_valid = 0; cr_resp = '0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic l);
      cd_valid = 1; cd_data = d; cd_last = l;
      @(negedge clk);
      cd_valid = 0; cd_data = '0; cd_last = 0;
   endtask

   // Runs one transaction up to a valid result; with hold=0 the result is consumed.
   task automatic run_vec(input vec_t v, input int idx, input bit hold);
      req_valid = 1; req_addr = v.addr; req_snoop = v.snoop;
      @(negedge clk);
      req_valid = 0;
      chk("ac_req", {ac_valid_o, ac_addr_o, ac_snoop_o, ac_prot_o}, {1'b1, v.exp_addr, v.snoop, 3'b000});
      repeat (v.ac_wait) @(negedge clk);
      chk("ac_hold", {ac_valid_o, ac_addr_o, ac_snoop_o, req_ready_o}, {1'b1, v.exp_addr, v.snoop, 1'b0});
      ac_ready = 1;
      @(negedge clk);
      ac_ready = 0;
      chk("ac_hs", {ac_valid_o, cr_ready_o, cd_ready_o}, 3'b011);
      case (v.mode)
         0: begin
            send_cr(v.cr);
            for (int i = 0; i < v.nbeats; i++) send_beat(v.beat[i], i == v.last_idx);
         end
         1: begin
            for (int i = 0; i < v.nbeats; i++) send_beat(v.beat[i], i == v.last_idx);
            send_cr(v.cr);
         end
         default: begin
            for (int i = 0; i < v.last_idx; i++) send_beat(v.beat[i], 1'b0);
            cr_valid = 1; cr_resp = v.cr;
            send_beat(v.beat[v.last_idx], 1'b1);
            cr_valid = 0; cr_resp = '0;
         end
      endcase
      // Result must appear the cycle after the final handshake.
      chk("rsp_latency", rsp_valid_o, 1'b1);
      for (int k = 0; k < 20 && !rsp_valid_o; k++) @(negedge clk);
      chk("rsp_data", rsp_data_o, v.exp_data);
      chk("rsp_cr_err", {rsp_crresp_o, rsp_err_o}, {v.exp_cr, v.exp_err});
      chk("done_ctl", {ac_valid_o, cr_ready_o, cd_ready_o, req_ready_o}, 4'b0000);
      $display("vec %0d: snoop=%h addr=%h crresp=%b err=%b data=%h",
               idx, v.snoop, v.addr, rsp_crresp_o, rsp_err_o, rsp_data_o);
      if (!hold) begin
         rsp_ready = 1;
         @(negedge clk);
         rsp_ready = 0;
         chk("back_idle", {req_ready_o, rsp_valid_o}, 2'b10);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench watchdog");
   end

   initial begin
      logic r2, r3;
      int   n;

      tbl[0] = mk(4'h1, 64'h0000_0000_8000_0048, 2, 0, 5'b01001, 2, 1,
                  64'hAAAA, 64'hBBBB, 64'h0, 64'h0000_0000_8000_0040,
                  {64'hBBBB, 64'hAAAA}, 5'b01001, 1'b0);
      tbl[1] = mk(4'h7, 64'h1234_5678_9ABC_DEF7, 0, 1, 5'b10101, 2, 1,
                  64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h0,
                  64'h1234_5678_9ABC_DEF0,
                  {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444}, 5'b10101, 1'b0);
      tbl[2] = mk(4'h0, 64'h40, 1, 0, 5'b00001, 1, 0,
                  64'hCAFE, 64'h0, 64'h0, 64'h40, {64'h0, 64'hCAFE}, 5'b00001, 1'b1);
      tbl[3] = mk(4'h9, 64'h100F, 1, 0, 5'b00000, 0, 0,
                  64'h0, 64'h0, 64'h0, 64'h1000, 128'h0, 5'b00000, 1'b0);
      tbl[4] = mk(4'h1, 64'h2008, 0, 0, 5'b00001, 3, 2,
                  64'hD1, 64'hD2, 64'hD3, 64'h2000, {64'hD2, 64'hD1}, 5'b00001, 1'b1);
      tbl[5] = mk(4'h1, 64'h3FFF, 3, 2, 5'b00101, 2, 1,
                  64'h55, 64'h66, 64'h0, 64'h3FF0, {64'h66, 64'h55}, 5'b00101, 1'b0);
      tbl[6] = mk(4'hD, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 5'b00010, 0, 0,
                  64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 128'h0, 5'b00010, 1'b0);

      idle_inputs();
      repeat (3) @(negedge clk);
      chk_reset_vals("in_reset");
      rst_n = 1;
      @(negedge clk);
      chk_reset_vals("after_reset");

      for (int i = 0; i < 7; i++) run_vec(tbl[i], i, 1'b0);

      // Minimum turnaround: accept, AC handshake, CR, then result in the fourth cycle.
      ac_ready = 1; req_valid = 1; req_addr = 64'h2000; req_snoop = 4'h9;
      @(negedge clk);
      req_valid = 0;
      chk("turn_ac", ac_valid_o, 1'b1);
      @(negedge clk);
      ac_ready = 0;
      r2 = rsp_valid_o;
      chk("turn_cr_ready", cr_ready_o, 1'b1);
      send_cr(5'b00000);
      r3 = rsp_valid_o;
      chk("turnaround", {r2, r3, cd_ready_o, rsp_data_o}, {1'b0, 1'b1, 1'b0, 128'h0});
      $display("turnaround: rsp_valid after CR accept, crresp=%b", rsp_crresp_o);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;

      // Result held stable while the requester stalls.
      run_vec(mk(4'h1, 64'h3008, 0, 0, 5'b01001, 2, 1, 64'h77, 64'h88, 64'h0,
                 64'h3000, {64'h88, 64'h77}, 5'b01001, 1'b0), 7, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_ctl", {rsp_valid_o, req_ready_o, rsp_crresp_o, rsp_err_o},
             {1'b1, 1'b0, 5'b01001, 1'b0});
         chk("hold_data", rsp_data_o, {64'h88, 64'h77});
      end
      $display("hold: result stable for 5 stalled cycles");
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;

      // Asynchronous reset in the middle of DATA.
      req_valid = 1; req_addr = 64'h4000; req_snoop = 4'h1;
      @(negedge clk);
      req_valid = 0; ac_ready = 1;
      @(negedge clk);
      ac_ready = 0;
      send_cr(5'b00001);
      send_beat(64'h99, 1'b0);
      chk("mid_data", {cd_ready_o, rsp_valid_o, rsp_data_o}, {1'b1, 1'b0, {64'h0, 64'h99}});
      #2 rst_n = 0;
      #1 chk_reset_vals("async_reset");
      $display("reset: asserted mid-DATA");
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk_reset_vals("after_reset2");

`ifdef ACE_SNOOP_INIT_TIMEOUT_EN
      // Watchdog: no CR ever, result must appear 16 cycles after the AC handshake.
      req_valid = 1; req_addr = 64'h5000; req_snoop = 4'h1; ac_ready = 1;
      @(negedge clk);
      req_valid = 0;
      n = 0;
      do begin
         @(negedge clk);
         ac_ready = 0;
         n++;
      end while (!rsp_valid_o && n < 40);
      chk("timeout_lat", n, 16);
      chk("timeout_rsp", {rsp_valid_o, rsp_err_o, rsp_crresp_o, cr_ready_o, cd_ready_o, ac_valid_o},
          {1'b1, 1'b1, 5'b00010, 3'b000});
      $display("timeout: result after %0d cycles, crresp=%b err=%b", n, rsp_crresp_o, rsp_err_o);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("timeout_idle", {req_ready_o, rsp_valid_o}, 2'b10);
`else
      n = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
